// File: rtl/cache_port_arbiter.sv
// Arbitrates the single data-cache port between the core (C, priority) and the loader (L).
// Optional BUSY watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter #(
    parameter int STREAK  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_valid,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic [31:0] l_rdata,
    output logic        l_valid,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    output logic        cache_re,
    output logic        cache_we,
    input  logic [31:0] cache_rdata,
    input  logic        cache_valid,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(STREAK);

    if (STREAK < 1 || STREAK > 15) begin : g_bad_streak
        $error("cache_port_arbiter: STREAK must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("cache_port_arbiter: TIMEOUT must be 1..1023");
    end

    logic [1:0]  state_q, state_d;
    logic        gnt_l_q, gnt_l_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] l_rdata_q, l_rdata_d;
    logic        pick_c;
    logic        timeout;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_V = 10'(TIMEOUT);

    logic [9:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;

    // Counter idles at zero outside BUSY, so it is effectively cleared on BUSY entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
    end

    assign timeout = (state_q == S_BUSY) && ((tmo_cnt_q + 10'd1) == TIMEOUT_V);
    assign err_d   = timeout && !cache_valid;

    always_ff @(posedge clk) begin
        if (rstn) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign pick_c = c_req && !(l_req && (streak_q == STREAK_MAX));

    always_comb begin
        state_d   = state_q;
        gnt_l_d   = gnt_l_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        streak_d  = streak_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (!l_req) begin
                    streak_d = '0;
                end
                if (c_req || l_req) begin
                    state_d = S_BUSY;
                    gnt_l_d = !pick_c;
                    if (pick_c) begin
                        we_d    = c_we;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                        if (l_req) begin
                            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                        end
                    end else begin
                        we_d     = l_we;
                        addr_d   = l_addr;
                        wdata_d  = l_wdata;
                        streak_d = '0;
                    end
                end
            end
            S_BUSY: begin
                // A completing cache access takes precedence over a coincident timeout.
                if (cache_valid) begin
                    state_d = S_RESP;
                    if (gnt_l_q) l_rdata_d = cache_rdata;
                    else         c_rdata_d = cache_rdata;
                end else if (timeout) begin
                    state_d = S_RESP;
                    if (gnt_l_q) l_rdata_d = '0;
                    else         c_rdata_d = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            gnt_l_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            streak_q  <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_l_q   <= gnt_l_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            streak_q  <= streak_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    assign cache_re    = (state_q == S_BUSY) && !we_q;
    assign cache_we    = (state_q == S_BUSY) && we_q;
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;
    assign c_valid     = (state_q == S_RESP) && !gnt_l_q;
    assign l_valid     = (state_q == S_RESP) && gnt_l_q;
    assign c_rdata     = c_rdata_q;
    assign l_rdata     = l_rdata_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed transactions, decoupled response monitor.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [31:0] c_rdata, l_rdata;
    logic        c_valid, l_valid;
    logic [31:0] cache_addr, cache_wdata, cache_rdata;
    logic        cache_re, cache_we, cache_valid;
    logic        busy, err;

    logic        mdl_valid, poke_valid;
    int          cache_lat;
    bit          cache_en;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        is_l;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    assign cache_valid = mdl_valid | poke_valid;

    always #5 clk = ~clk;

    cache_port_arbiter #(.STREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_valid(c_valid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_valid(l_valid),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_re(cache_re), .cache_we(cache_we),
        .cache_rdata(cache_rdata), .cache_valid(cache_valid),
        .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Cache model: answers after cache_lat strobe cycles
    initial begin
        int bcnt;
        bcnt        = 0;
        mdl_valid   = 1'b0;
        cache_rdata = '0;
        forever begin
            @(negedge clk);
            if (cache_en && (cache_re || cache_we)) begin
                bcnt++;
                if (bcnt >= cache_lat) begin
                    mdl_valid   = 1'b1;
                    cache_rdata = mem_rd(cache_addr);
                end else begin
                    mdl_valid = 1'b0;
                end
            end else begin
                mdl_valid = 1'b0;
                bcnt      = 0;
            end
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (c_valid === 1'b1 || l_valid === 1'b1) begin
                if (c_valid && l_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL both_valid: c_valid=1 l_valid=1 expected one");
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: c_valid=%0b l_valid=%0b expected none", c_valid, l_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_port", {31'b0, l_valid}, {31'b0, mon_e.is_l});
                    chk("resp_rdata", l_valid ? l_rdata : c_rdata, mon_e.rdata);
                    chk("resp_err", {31'b0, err}, {31'b0, mon_e.err});
                end
            end
        end
    end

    task automatic wait_resp(input int n, input int budget);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (c_valid || l_valid) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL wait_resp: got %0d responses expected %0d", seen, n);
        end
    endtask

    task automatic issue(input bit is_l, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input bit exp_err, input bit perturb,
                         output int strobes, output int first);
        int  t    = 0;
        bit  done = 0;
        exp_t e;
        @(negedge clk);
        if (is_l) begin
            l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        e.is_l  = is_l;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        strobes = 0;
        first   = -1;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
            if (cache_re || cache_we) begin
                if (first < 0) first = t;
                strobes++;
                chk("strobe_we", {31'b0, cache_we}, {31'b0, we});
                chk("addr_hold", cache_addr, addr);
                if (we) chk("wdata_hold", cache_wdata, wdata);
                if (perturb) begin
                    c_addr  = 32'hFFFF_0000;
                    c_wdata = 32'h0BAD_F00D;
                end
            end
            if (c_valid || l_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: no response after %0d cycles expected one", t);
        end
        c_req = 1'b0;
        l_req = 1'b0;
    endtask

    initial begin
        int s, f;
        exp_t e;
        rstn = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        poke_valid = 1'b0;
        cache_en   = 1'b1;
        cache_lat  = 1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);

        chk("rst_cache_re", {31'b0, cache_re}, 32'd0);
        chk("rst_cache_we", {31'b0, cache_we}, 32'd0);
        chk("rst_cache_addr", cache_addr, 32'd0);
        chk("rst_cache_wdata", cache_wdata, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        chk("rst_valids", {30'b0, c_valid, l_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);

        // C load, 2-cycle cache
        cache_lat = 2;
        issue(0, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, s, f);
        chk("c_load_strobes", s, 32'd2);
        chk("c_load_latency", f, 32'd1);

        // Both requesting continuously: C,C,C,C,L,C,C,C,C,L
        cache_lat = 1;
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h40;
        l_req = 1; l_we = 0; l_addr = 32'h80;
        for (int i = 0; i < 10; i++) begin
            e.is_l  = (i == 4 || i == 9);
            e.rdata = e.is_l ? 32'h5A5A_0080 : 32'h5A5A_0040;
            e.err   = 1'b0;
            sb.push_back(e);
        end
        wait_resp(10, 100);
        c_req = 0;
        l_req = 0;
        repeat (2) @(negedge clk);

        // L store with 3-cycle cache
        cache_lat = 3;
        issue(1, 1, 32'h0000_2000, 32'h1234_5678, 32'h5A5A_2000, 0, 0, s, f);
        chk("l_store_strobes", s, 32'd3);

        // C address changes while BUSY
        issue(0, 0, 32'h0000_0400, 32'h0, 32'h5A5A_0400, 0, 1, s, f);
        chk("perturb_strobes", s, 32'd3);
        repeat (2) @(negedge clk);

        // Reset while BUSY, then a stray cache_valid
        cache_en = 1'b0;
        c_req = 1; c_we = 0; c_addr = 32'h300;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rstn  = 1'b1;
        c_req = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_strobes", {30'b0, cache_re, cache_we}, 32'd0);
        poke_valid = 1'b1;
        @(negedge clk);
        poke_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_valid_busy", {31'b0, busy}, 32'd0);
        chk("late_valid_rdata", c_rdata, 32'd0);

`ifdef CACHE_ARB_TIMEOUT_EN
        issue(0, 0, 32'h0000_0500, 32'h0, 32'h0, 1, 0, s, f);
        chk("timeout_strobes", s, 32'd8);
`else
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h500;
        repeat (40) @(negedge clk);
        chk("hang_busy", {31'b0, busy}, 32'd1);
        chk("hang_cache_re", {31'b0, cache_re}, 32'd1);
        chk("hang_err", {31'b0, err}, 32'd0);
        rstn  = 1'b1;
        c_req = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
`endif

        // Recovery: L load, 1-cycle cache
        cache_en  = 1'b1;
        cache_lat = 1;
        issue(1, 0, 32'h0000_0600, 32'h0, 32'h5A5A_0600, 0, 0, s, f);
        chk("recover_strobes", s, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
